// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor: state encoding and counter sizing helper.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_sup_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous status bit; resets to 0.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_ff <= '0;
    else        sync_ff <= {sync_ff[STAGES-2:0], d};
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, qualifies its asynchronous lock and releases a clean
// downstream reset; retries on timeout or lock loss, parks in FAULT after MAX_RETRY.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES     = 256,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRY           = 7,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] state_o
);

  localparam int unsigned MAX_A   = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_W   = (clog2(MAX_CNT) < 1) ? 1 : clog2(MAX_CNT);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

  pll_sup_state_e   state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       retry_nxt;
  logic [7:0]       loss_nxt;
  logic             lock_sync;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_sync)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    retry_nxt = retry_cnt;
    loss_nxt  = lock_loss_cnt;

    case (state)
      ST_HOLD: begin
        if (cnt == HOLD_LAST) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_sync) begin
          state_nxt = ST_STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          if (retry_cnt == RETRY_LIMIT) begin
            state_nxt = ST_FAULT;
          end else begin
            retry_nxt = retry_cnt + 1'b1;
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_STABLE: begin
        if (!lock_sync)                state_nxt = ST_WAIT_LOCK;
        else if (cnt == STABLE_LAST)   state_nxt = ST_RUN;
      end
      ST_RUN: begin
        cnt_nxt = '0;
        if (!lock_sync) begin
          state_nxt = ST_HOLD;
          if (lock_loss_cnt != '1) loss_nxt = lock_loss_cnt + 1'b1;
        end
      end
      ST_FAULT: begin
        cnt_nxt = '0;
      end
      default: state_nxt = ST_HOLD;
    endcase

    // Relock overrides the transition but a simultaneous lock loss is still counted.
    if (force_relock) begin
      state_nxt = ST_HOLD;
      retry_nxt = '0;
    end

    if (force_relock || state_nxt != state) cnt_nxt = '0;
    if (state_nxt == ST_RUN) retry_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_HOLD;
      cnt           <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_rst       <= 1'b1;
      sys_rst_n     <= 1'b0;
      locked        <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      retry_cnt     <= retry_nxt;
      lock_loss_cnt <= loss_nxt;
      pll_rst       <= (state_nxt == ST_HOLD) || (state_nxt == ST_FAULT);
      sys_rst_n     <= (state_nxt == ST_RUN);
      locked        <= (state_nxt == ST_RUN);
      fault         <= (state_nxt == ST_FAULT);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with shortened timing parameters.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       force_relock;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       locked;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .RST_HOLD_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRY           (2),
    .SYNC_STAGES         (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_lock      (pll_lock),
    .force_relock  (force_relock),
    .pll_rst       (pll_rst),
    .sys_rst_n     (sys_rst_n),
    .locked        (locked),
    .fault         (fault),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt),
    .state_o       (state_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n;
    n = 0;
    while (state_o !== s && n < budget) begin
      tick();
      n++;
    end
    check(tag, {29'd0, state_o}, {29'd0, s});
  endtask

  initial begin
    rst_n        = 1'b0;
    pll_lock     = 1'b0;
    force_relock = 1'b0;
    #12;
    check("rst_state", state_o, 0);
    check("rst_pll_rst", pll_rst, 1);
    check("rst_sys_rst_n", sys_rst_n, 0);
    check("rst_locked", locked, 0);
    check("rst_fault", fault, 0);
    check("rst_retry", retry_cnt, 0);
    check("rst_loss", lock_loss_cnt, 0);

    // 1: pll_rst held for exactly 4 cycles after release
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check("hold_e1_pll_rst", pll_rst, 1);
    ticks(2);
    check("hold_e3_pll_rst", pll_rst, 1);
    check("hold_e3_state", state_o, 0);
    tick();
    check("hold_e4_pll_rst", pll_rst, 0);
    check("hold_e4_state", state_o, 1);

    // 2: lock first sampled at e7, RUN after e17
    ticks(2);
    pll_lock = 1'b1;
    tick();
    tick();
    check("lat_e8_state", state_o, 1);
    tick();
    check("lat_e9_state", state_o, 2);
    ticks(7);
    check("lat_e16_locked", locked, 0);
    check("lat_e16_sys_rst_n", sys_rst_n, 0);
    tick();
    check("lat_e17_locked", locked, 1);
    check("lat_e17_sys_rst_n", sys_rst_n, 1);
    check("lat_e17_state", state_o, 3);
    check("lat_e17_retry", retry_cnt, 0);
    check("lat_e17_pll_rst", pll_rst, 0);

    // 5a: lock loss in RUN
    pll_lock = 1'b0;
    ticks(2);
    check("loss_pre_locked", locked, 1);
    tick();
    check("loss_locked", locked, 0);
    check("loss_sys_rst_n", sys_rst_n, 0);
    check("loss_state", state_o, 0);
    check("loss_cnt1", lock_loss_cnt, 1);
    check("loss_pll_rst", pll_rst, 1);
    ticks(3);
    check("loss_hold3_pll_rst", pll_rst, 1);
    tick();
    check("loss_hold4_pll_rst", pll_rst, 0);
    check("loss_hold4_state", state_o, 1);

    // 3: timeouts, then FAULT, then force_relock
    ticks(19);
    check("to1_pre_state", state_o, 1);
    check("to1_pre_retry", retry_cnt, 0);
    tick();
    check("to1_state", state_o, 0);
    check("to1_retry", retry_cnt, 1);
    ticks(4);
    check("to1_wait_state", state_o, 1);
    ticks(20);
    check("to2_state", state_o, 0);
    check("to2_retry", retry_cnt, 2);
    ticks(4);
    check("to2_wait_state", state_o, 1);
    ticks(19);
    check("to3_pre_state", state_o, 1);
    tick();
    check("fault_state", state_o, 4);
    check("fault_fault", fault, 1);
    check("fault_pll_rst", pll_rst, 1);
    check("fault_sys_rst_n", sys_rst_n, 0);
    check("fault_retry", retry_cnt, 2);
    ticks(5);
    check("fault_stay_state", state_o, 4);
    check("fault_stay_fault", fault, 1);
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    check("relock_state", state_o, 0);
    check("relock_retry", retry_cnt, 0);
    check("relock_fault", fault, 0);
    check("relock_pll_rst", pll_rst, 1);

    // 4: one-cycle lock glitch during STABLE
    pll_lock = 1'b1;
    ticks(3);
    check("g_hold_state", state_o, 0);
    tick();
    check("g_wait_state", state_o, 1);
    check("g_wait_pll_rst", pll_rst, 0);
    tick();
    check("g_stable_state", state_o, 2);
    ticks(3);
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    tick();
    check("g_cnt5_state", state_o, 2);
    tick();
    check("g_back_wait_state", state_o, 1);
    check("g_back_wait_retry", retry_cnt, 0);
    tick();
    check("g_restable_state", state_o, 2);
    ticks(7);
    check("g_restable7_state", state_o, 2);
    tick();
    check("g_run_state", state_o, 3);
    check("g_run_locked", locked, 1);
    check("g_run_retry", retry_cnt, 0);

    // 6b: force_relock coincides with lock_sync falling in RUN
    pll_lock = 1'b0;
    ticks(2);
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    check("fr_state", state_o, 0);
    check("fr_loss", lock_loss_cnt, 2);
    check("fr_retry", retry_cnt, 0);
    check("fr_locked", locked, 0);
    check("fr_sys_rst_n", sys_rst_n, 0);
    check("fr_pll_rst", pll_rst, 1);

    // 5b: saturation of lock_loss_cnt
    pll_lock = 1'b1;
    wait_state(3'd3, 40, "sat_first_run");
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      wait_state(3'd0, 10, "sat_to_hold");
      pll_lock = 1'b1;
      wait_state(3'd3, 40, "sat_to_run");
    end
    check("sat_loss", lock_loss_cnt, 255);

    // 6a: asynchronous reset mid-STABLE
    pll_lock = 1'b0;
    wait_state(3'd0, 10, "ar_to_hold");
    pll_lock = 1'b1;
    wait_state(3'd2, 20, "ar_to_stable");
    ticks(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_state", state_o, 0);
    check("ar_pll_rst", pll_rst, 1);
    check("ar_sys_rst_n", sys_rst_n, 0);
    check("ar_locked", locked, 0);
    check("ar_fault", fault, 0);
    check("ar_retry", retry_cnt, 0);
    check("ar_loss", lock_loss_cnt, 0);
    #10;
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
